// File: rtl/blc_line_tx.sv
// Line transmitter for the black-level-correction receiver: frames upstream active pixels with
// a lead pixel, left/right optical-black runs carrying offset plus masked LFSR noise, and a trailer.
module blc_line_tx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BPN_L      = 100,
   parameter int unsigned READ_PIXEL = 16,
   parameter int unsigned BPN_R      = 100,
   parameter int unsigned GAP_CYCLES = 32,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] black_level,
   input  logic [DATA_WIDTH-1:0] noise_mask,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  blc_ready,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  line_done,
   output logic                  busy,
   output logic [15:0]           line_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StLead,
      StBlackL,
      StActive,
      StBlackR,
      StTrail,
      StGap
   } state_e;

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] LastL   = CW'(BPN_L - 1);
   localparam logic [CW-1:0] LastAct = CW'(READ_PIXEL - 1);
   localparam logic [CW-1:0] LastR   = CW'(BPN_R - 1);
   localparam logic [CW-1:0] LastGap = CW'(GAP_CYCLES - 1);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic                  o_valid_q, o_valid_d;
   logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
   logic                  line_done_q, line_done_d;
   logic [15:0]           line_cnt_q, line_cnt_d;

   logic [DATA_WIDTH:0]   black_sum;
   logic [DATA_WIDTH:0]   active_sum;
   logic [DATA_WIDTH-1:0] black_pix;
   logic [DATA_WIDTH-1:0] active_pix;
   logic [15:0]           lfsr_next;

   // Sums are one bit wider so the carry drives saturation to all-ones.
   assign black_sum  = {1'b0, black_level} + {1'b0, lfsr_q[DATA_WIDTH-1:0] & noise_mask};
   assign active_sum = {1'b0, a_data} + {1'b0, black_level};
   assign black_pix  = black_sum[DATA_WIDTH] ? '1 : black_sum[DATA_WIDTH-1:0];
   assign active_pix = active_sum[DATA_WIDTH] ? '1 : active_sum[DATA_WIDTH-1:0];

   // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
   assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         o_valid_q   <= 1'b0;
         o_data_q    <= '0;
         line_done_q <= 1'b0;
         line_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         o_valid_q   <= o_valid_d;
         o_data_q    <= o_data_d;
         line_done_q <= line_done_d;
         line_cnt_q  <= line_cnt_d;
      end
   end

   // Each state decides the pixel that appears on the output one cycle later; the lead pixel
   // is therefore decided in IDLE and is on the bus while the FSM sits in LEAD.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lfsr_d      = lfsr_q;
      o_valid_d   = 1'b0;
      o_data_d    = '0;
      line_done_d = 1'b0;
      line_cnt_d  = line_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (en && blc_ready) begin
               o_valid_d = 1'b1;
               state_d   = StLead;
            end
         end
         StLead, StBlackL: begin
            o_valid_d = 1'b1;
            o_data_d  = black_pix;
            lfsr_d    = lfsr_next;
            if (cnt_q == LastL) begin
               state_d = StActive;
               cnt_d   = '0;
            end else begin
               state_d = StBlackL;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         StActive: begin
            if (a_valid) begin
               o_valid_d = 1'b1;
               o_data_d  = active_pix;
               if (cnt_q == LastAct) begin
                  state_d = StBlackR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StBlackR: begin
            o_valid_d = 1'b1;
            o_data_d  = black_pix;
            lfsr_d    = lfsr_next;
            if (cnt_q == LastR) begin
               state_d = StTrail;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StTrail: begin
            o_valid_d = 1'b1;
            state_d   = StGap;
            cnt_d     = '0;
         end
         StGap: begin
            // First GAP cycle is the one where the trailer is on the bus.
            if (cnt_q == '0) begin
               line_done_d = 1'b1;
               line_cnt_d  = line_cnt_q + 1'b1;
            end
            if (cnt_q == LastGap) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign a_ready   = (state_q == StActive);
   assign busy      = (state_q != StIdle);
   assign o_valid   = o_valid_q;
   assign o_data    = o_data_q;
   assign line_done = line_done_q;
   assign line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_blc_line_tx.sv
// Scoreboard bench for blc_line_tx: a line-level model queues expected pixels per line and a
// monitor pops them whenever o_valid is seen, also checking framing, line_done and line_cnt.
module tb_blc_line_tx;

   localparam int DW       = 8;
   localparam int NBL      = 100;
   localparam int NRP      = 16;
   localparam int NBR      = 100;
   localparam int NGAP     = 32;
   localparam int LINE_LEN = NBL + NRP + NBR + 2;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [DW-1:0] black_level;
   logic [DW-1:0] noise_mask;
   logic          a_valid;
   logic          a_ready;
   logic [DW-1:0] a_data;
   logic          blc_ready;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          line_done;
   logic          busy;
   logic [15:0]   line_cnt;

   blc_line_tx #(
      .DATA_WIDTH(DW),
      .BPN_L     (NBL),
      .READ_PIXEL(NRP),
      .BPN_R     (NBR),
      .GAP_CYCLES(NGAP),
      .LFSR_SEED (SEED)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .black_level(black_level),
      .noise_mask (noise_mask),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_data     (a_data),
      .blc_ready  (blc_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .line_done  (line_done),
      .busy       (busy),
      .line_cnt   (line_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Scoreboard and model state
   int          exp_data[$];
   bit          exp_last[$];
   int          src[$];
   logic [15:0] m_lfsr = SEED;
   int          lines_exp = 0;

   // Monitor state
   int line_pix     = 0;
   int idle_run     = 0;
   bit prev_trailer = 1'b0;
   int mon_holes    = 0;

   // Driver state
   bit drv_pending = 1'b0;
   bit rand_valid  = 1'b0;
   int drop_arm    = 0;
   int drop_cnt    = 0;
   int drv_holes   = 0;

   task automatic check(input string name, input int got, input int expv);
      n_total++;
      if (got == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, expv);
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic push_black(input int bl, input int mask);
      exp_data.push_back(sat(bl + (int'(m_lfsr[7:0]) & mask)));
      exp_last.push_back(1'b0);
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
   endtask

   // kind: 0 = ramp 0..15, 1 = constant 10, 2 = random
   task automatic push_line(input int bl, input int mask, input int kind);
      int d;
      black_level = DW'(bl);
      noise_mask  = DW'(mask);
      exp_data.push_back(0);
      exp_last.push_back(1'b0);
      repeat (NBL) push_black(bl, mask);
      for (int i = 0; i < NRP; i++) begin
         d = (kind == 0) ? i : (kind == 1) ? 10 : int'($urandom_range(0, 255));
         src.push_back(d);
         exp_data.push_back(sat(d + bl));
         exp_last.push_back(1'b0);
      end
      repeat (NBR) push_black(bl, mask);
      exp_data.push_back(0);
      exp_last.push_back(1'b1);
   endtask

   task automatic wait_line(input string name);
      int start;
      int k;
      start = lines_exp;
      k = 0;
      while (lines_exp == start && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check({name, "_line_complete"}, lines_exp - start, 1);
   endtask

   // Upstream source: transfer decided at negedge is consumed at the following posedge.
   initial begin
      a_valid = 1'b0;
      a_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            a_valid     = 1'b0;
            drv_pending = 1'b0;
         end else begin
            if (drv_pending && src.size() > 0) begin
               void'(src.pop_front());
               if (drop_arm > 0) begin
                  drop_arm--;
                  if (drop_arm == 0) drop_cnt = 5;
               end
            end
            if (drop_cnt > 0 && a_ready) begin
               a_valid = 1'b0;
               drop_cnt--;
            end else if (src.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
               a_valid = 1'b1;
               a_data  = DW'(src[0]);
            end else begin
               a_valid = 1'b0;
            end
            drv_pending = a_valid && a_ready;
            if (a_ready && !a_valid) drv_holes++;
         end
      end
   end

   // Monitor
   initial begin
      int e;
      bit last;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (line_done) begin
               check("line_done_after_trailer", int'(prev_trailer), 1);
               lines_exp++;
               check("line_cnt", int'(line_cnt), lines_exp & 16'hFFFF);
               check("line_length", line_pix, LINE_LEN);
               check("line_holes", mon_holes, drv_holes);
               line_pix = 0;
            end else if (prev_trailer) begin
               check("line_done_after_trailer", int'(line_done), 1);
            end
            prev_trailer = 1'b0;
            if (o_valid) begin
               if (exp_data.size() == 0) begin
                  check("exp_queue_at_pixel", exp_data.size(), 1);
               end else begin
                  e    = exp_data.pop_front();
                  last = exp_last.pop_front();
                  check("pixel", int'(o_data), e);
                  prev_trailer = last;
               end
               if (line_pix == 0 && lines_exp > 0) check("inter_line_gap", int'(idle_run >= NGAP), 1);
               else if (line_pix > 0) mon_holes += idle_run;
               line_pix++;
               idle_run = 0;
            end else begin
               idle_run++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0;
      int cnt;
      int k;
      rst_n       = 1'b1;
      en          = 1'b0;
      blc_ready   = 1'b0;
      black_level = '0;
      noise_mask  = '0;
      #3 rst_n = 1'b0;
      #5;
      check("reset_o_valid", int'(o_valid), 0);
      check("reset_o_data", int'(o_data), 0);
      check("reset_line_done", int'(line_done), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_line_cnt", int'(line_cnt), 0);
      check("reset_a_ready", int'(a_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Defaults line with ramp input
      push_line(16, 0, 0);
      en        = 1'b1;
      blc_ready = 1'b1;
      wait_line("ramp");

      // Saturation with full noise
      push_line(250, 8'hFF, 1);
      wait_line("saturate");

      // a_valid dropped for 5 cycles after the third active pixel
      drop_arm = 3;
      h0 = mon_holes;
      push_line(int'($urandom_range(0, 200)), int'($urandom_range(0, 255)), 2);
      wait_line("drop");
      check("drop_hole_cycles", mon_holes - h0, 5);

      // Random lines with random upstream valid
      rand_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         push_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2);
         wait_line("random");
      end

      // Receiver not ready: block must sit idle, then start on the next cycle
      @(negedge clk);
      blc_ready = 1'b0;
      cnt = 0;
      repeat (NGAP + 10) begin
         @(negedge clk);
         if (o_valid) cnt++;
      end
      check("not_ready_no_pixels", cnt, 0);
      check("not_ready_busy", int'(busy), 0);
      push_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2);
      blc_ready = 1'b1;
      @(negedge clk);
      check("lead_latency_valid", int'(o_valid), 1);
      check("lead_latency_data", int'(o_data), 0);
      wait_line("after_ready");

      // Reset during ACTIVE
      push_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2);
      k = 0;
      while (!a_ready && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("reach_active", int'(a_ready), 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midline_reset_o_valid", int'(o_valid), 0);
      check("midline_reset_line_cnt", int'(line_cnt), 0);
      check("midline_reset_busy", int'(busy), 0);
      exp_data.delete();
      exp_last.delete();
      src.delete();
      m_lfsr       = SEED;
      lines_exp    = 0;
      line_pix     = 0;
      idle_run     = 0;
      prev_trailer = 1'b0;
      mon_holes    = 0;
      drv_holes    = 0;
      drop_cnt     = 0;
      drop_arm     = 0;
      drv_pending  = 1'b0;
      push_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_line("post_reset");
      check("post_reset_line_cnt", int'(line_cnt), 1);

      // en dropped during BLACK_L: line finishes, then no more lines
      push_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2);
      k = 0;
      while (!o_valid && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("en_test_line_started", int'(o_valid), 1);
      repeat (10) @(negedge clk);
      en = 1'b0;
      wait_line("en_drop");
      cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (o_valid) cnt++;
      end
      check("en_drop_no_more_pixels", cnt, 0);
      check("en_drop_line_cnt", int'(line_cnt), 2);
      check("en_drop_idle", int'(busy), 0);
      check("scoreboard_drained", exp_data.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
